// File: rtl/sig_sel_pkg.sv
// Shared types and constants for the glitch-free sample selector.
// Optional crossing timeout is enabled with MSS_ZC_TIMEOUT_EN.
package sig_sel_pkg;

  localparam int SS_W    = 12;
  localparam int SS_N_CH = 8;

  typedef enum logic {
    SS_IDLE,
    SS_PENDING
  } ss_state_t;

  function automatic int unsigned midscale(int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sig_select_seq_zc_detect.sv
// Rising midscale crossing detector: remembers the last strobed sample
// and flags when the current sample crosses up through midscale.
import sig_sel_pkg::*;

module zc_detect #(
  parameter int W = SS_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sample_en,
  input  logic [W-1:0] s,
  output logic         zc
);

  localparam logic [W-1:0] MID = W'(midscale(W));

  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev <= MID;
    end else if (sample_en) begin
      prev <= s;
    end
  end

  assign zc = (prev < MID) && (s >= MID);

endmodule

// File: rtl/sig_select_seq.sv
// Registered channel selector; switches commit on a rising midscale crossing.
// Define MSS_ZC_TIMEOUT_EN to force a switch after TIMEOUT strobes.
import sig_sel_pkg::*;

module sig_select_seq #(
  parameter int W       = SS_W,
  parameter int N_CH    = SS_N_CH,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_en,
  input  logic [N_CH*W-1:0] ch_data,
  input  logic [SELW-1:0] sel_req,
  input  logic            sel_update,
  output logic [W-1:0]    sel_out,
  output logic            sel_valid,
  output logic [SELW-1:0] active_sel,
  output logic            pending,
  output logic            sel_err
);

  localparam logic [W-1:0] MID = W'(midscale(W));

  if (N_CH < 2 || (2 ** SELW) < N_CH || TIMEOUT < 2) begin : g_param_err
    $error("sig_select_seq: inconsistent parameters");
  end

  ss_state_t       state, state_n;
  logic [SELW-1:0] target, target_n;
  logic [SELW-1:0] active_n;
  logic [W-1:0]    s;
  logic            zc;
  logic            req_ok;
  logic            err_n;
  logic            expire;

`ifdef MSS_ZC_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt, cnt_n;
  assign expire = (cnt == CW'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    s = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (active_sel == SELW'(k)) s = ch_data[k*W +: W];
    end
  end

  zc_detect #(.W(W)) u_zc (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_en (sample_en),
    .s         (s),
    .zc        (zc)
  );

  assign req_ok  = (int'(sel_req) < N_CH);
  assign pending = (state == SS_PENDING);

  // A request in the same cycle as a crossing takes priority over the switch.
  always_comb begin
    state_n  = state;
    target_n = target;
    active_n = active_sel;
    err_n    = 1'b0;
`ifdef MSS_ZC_TIMEOUT_EN
    cnt_n    = cnt;
`endif
    if (sel_update) begin
      if (!req_ok) begin
        err_n = 1'b1;
      end else if (sel_req == active_sel) begin
        state_n = SS_IDLE;
      end else begin
        state_n  = SS_PENDING;
        target_n = sel_req;
`ifdef MSS_ZC_TIMEOUT_EN
        cnt_n    = '0;
`endif
      end
    end else if (state == SS_PENDING && sample_en) begin
      if (zc || expire) begin
        active_n = target;
        state_n  = SS_IDLE;
      end else begin
`ifdef MSS_ZC_TIMEOUT_EN
        cnt_n = cnt + CW'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= SS_IDLE;
      target     <= '0;
      active_sel <= '0;
      sel_out    <= MID;
      sel_valid  <= 1'b0;
      sel_err    <= 1'b0;
`ifdef MSS_ZC_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_n;
      target     <= target_n;
      active_sel <= active_n;
      sel_valid  <= sample_en;
      sel_err    <= err_n;
      if (sample_en) sel_out <= s;
`ifdef MSS_ZC_TIMEOUT_EN
      cnt        <= cnt_n;
`endif
    end
  end

endmodule
